mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store sequencer sitting directly upstream of memory_unit, between the execute stage and the data memory.
- Accepts one memory request at a time from execute over a valid/ready handshake.
- Registers the request, range-checks the word address, then drives memory_unit's isLd/isSt/address/data_in.
- Captures load data and returns a tagged response over a second valid/ready handshake for write-back.

Parameters:
DATA_W, 32, data and address width (matches memory_unit ports)
MEM_DEPTH, 16, number of valid data-memory words; addresses >= MEM_DEPTH fault
WAIT_CYCLES, 1, cycles a load holds mem_isLd before data is captured (0..7)
TAG_W, 4, width of destination-register tag carried with the request

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  execute presents a request
req_ready  out  1  unit can accept a request this cycle
req_isLd  in  1  request is a load
req_isSt  in  1  request is a store
req_addr  in  DATA_W  word address
req_wdata  in  DATA_W  store data
req_tag  in  TAG_W  destination-register tag
rsp_valid  out  1  response available
rsp_ready  in  1  write-back accepts response
rsp_rdata  out  DATA_W  load data; 0 for stores, faults and no-ops
rsp_tag  out  TAG_W  tag of the completed request
rsp_fault  out  1  request was out of range or illegal
mem_isLd  out  1  to memory_unit isLd
mem_isSt  out  1  to memory_unit isSt
mem_address  out  DATA_W  to memory_unit address
mem_data_in  out  DATA_W  to memory_unit data_in
mem_data_out  in  DATA_W  from memory_unit data_out (combinational read)

Behaviour:
- Clock/reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_tag=0; rsp_fault=0; mem_isLd=0; mem_isSt=0; mem_address=0; mem_data_in=0.
- Handshakes:
  - Request accepted on rising edge with req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - Response transfers on rsp_valid & rsp_ready.
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On accept, register op, addr, wdata and tag.
  - fault = (isLd & isSt) | (addr >= MEM_DEPTH) for any load/store.
  - Next state ISSUE.
- ISSUE (1 cycle):
  - Store, no fault: mem_isSt=1 for exactly this cycle, with mem_address/mem_data_in = registered values; memory writes at the closing edge. Next state RESP.
  - Load, no fault: mem_isLd=1. If WAIT_CYCLES=0, capture mem_data_out into rsp_rdata at this edge and go to RESP; otherwise go to WAIT.
  - Fault or no-op (neither isLd nor isSt): no mem strobe; rsp_rdata=0. Next state RESP.
- WAIT:
  - mem_isLd=1 and mem_address held.
  - Down-counter runs WAIT_CYCLES cycles; rsp_rdata captured from mem_data_out on the final WAIT edge. Next state RESP.
- RESP:
  - rsp_valid=1; mem strobes=0.
  - On rsp_ready, go to IDLE.
  - Next request accepted no earlier than the cycle after the response transfers.
- Latency and throughput:
  - Store/fault/no-op: rsp_valid rises 2 cycles after accept.
  - Load: 2+WAIT_CYCLES cycles.
  - Max throughput: 1 request per 3+WAIT_CYCLES cycles with rsp_ready tied high.
- Boundaries:
  - addr = MEM_DEPTH-1 is legal; addr = MEM_DEPTH faults; upper address bits are never truncated.
  - mem_isLd and mem_isSt are never asserted in the same cycle.
  - Reset mid-operation aborts the operation. A store still in ISSUE when reset is sampled has already presented mem_isSt that cycle; the memory write on that edge is permitted.

Optional Feature:
MEM_ACCESS_STATS_EN
- Defined: adds outputs ld_count, st_count and fault_count, each 16 bits.
  - Each increments once per completed non-faulting load, non-faulting store, or faulting request respectively.
  - Increment occurs on response transfer.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - op encoding constants (OP_NOP, OP_LD, OP_ST, OP_ILL)
  - default MEM_DEPTH/DATA_W constants
- One sub-module, mem_addr_check: combinational fault = illegal-op | out-of-range, parameterised by MEM_DEPTH.

Test Plan:
- Store then load, WAIT_CYCLES=1: st addr=3 wdata=32'hDEAD_BEEF, then ld addr=3.
  - Store: mem_isSt high exactly 1 cycle; rsp_rdata=0.
  - Load: rsp_rdata=32'hDEADBEEF, rsp_valid 3 cycles after load accept, rsp_tag echoed.
- Load addr=10 with memory model word10=9 -> rsp_rdata=9, rsp_fault=0.
- Load addr=16 -> rsp_fault=1, rsp_rdata=0, mem_isLd never asserted.
- Load addr=15 -> legal, rsp_rdata = model word15 (2).
- Request with req_isLd=req_isSt=1 addr=2 -> rsp_fault=1, no mem strobes, memory word2 unchanged.
- Backpressure: rsp_ready=0 for 5 cycles after a load.
  - rsp_* stable; req_ready=0 throughout.
  - rsp_ready=1 -> IDLE next cycle.
- Reset: rst_n low during WAIT -> next cycle all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Brief    : Shared state, op encodings and default sizes for mem_access_unit.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int c_DEFAULT_DATA_W    = 32;
    localparam int c_DEFAULT_MEM_DEPTH = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Op code is simply {isSt, isLd}, so both strobes set lands on OP_ILL.
    typedef logic [1:0] op_t;
    localparam op_t OP_NOP = 2'b00;
    localparam op_t OP_LD  = 2'b01;
    localparam op_t OP_ST  = 2'b10;
    localparam op_t OP_ILL = 2'b11;

    function automatic op_t encode_op(input logic is_ld, input logic is_st);
        return {is_st, is_ld};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
//  Module   : mem_addr_check
//  Brief    : Combinational fault detect: illegal op or word address beyond
//             the data memory, checked on the full address width.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_addr_check
    import mem_access_pkg::*;
#(
    parameter int DATA_W    = c_DEFAULT_DATA_W,
    parameter int MEM_DEPTH = c_DEFAULT_MEM_DEPTH
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] addr,
    output logic              fault
);

    localparam logic [DATA_W-1:0] c_DEPTH = DATA_W'(MEM_DEPTH);

    logic w_illegal;
    logic w_out_of_range;

    assign w_illegal      = (op == OP_ILL);
    assign w_out_of_range = (op != OP_NOP) && (addr >= c_DEPTH);
    assign fault          = w_illegal | w_out_of_range;

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : One-at-a-time load/store sequencer in front of memory_unit.
//             Optional MEM_ACCESS_STATS_EN adds saturating ld/st/fault counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = c_DEFAULT_DATA_W,
    parameter int MEM_DEPTH   = c_DEFAULT_MEM_DEPTH,
    parameter int WAIT_CYCLES = 1,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_isLd,
    input  logic              req_isSt,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_fault,
    output logic              mem_isLd,
    output logic              mem_isSt,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]       ld_count,
    output logic [15:0]       st_count,
    output logic [15:0]       fault_count
`endif
);

    // Counter preload so that WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t            r_state;
    op_t               r_op;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_fault;
    logic [2:0]        r_wait_cnt;

    logic w_fault;
    logic w_do_ld;
    logic w_do_st;

    mem_addr_check #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_check (
        .op    (r_op),
        .addr  (r_addr),
        .fault (w_fault)
    );

    assign w_do_ld = (r_op == OP_LD) && !w_fault;
    assign w_do_st = (r_op == OP_ST) && !w_fault;

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_tag     = r_tag;
    assign rsp_fault   = r_rsp_fault;
    assign mem_isLd    = w_do_ld && ((r_state == ST_ISSUE) || (r_state == ST_WAIT));
    assign mem_isSt    = w_do_st && (r_state == ST_ISSUE);
    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tag       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= encode_op(req_isLd, req_isSt);
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_tag       <= req_tag;
                        r_rsp_rdata <= '0;
                        r_rsp_fault <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rsp_fault <= w_fault;
                    r_rsp_rdata <= '0;
                    if (w_do_ld && (WAIT_CYCLES != 0)) begin
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_state    <= ST_WAIT;
                    end else begin
                        if (w_do_ld) begin
                            r_rsp_rdata <= mem_data_out;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_rsp_rdata <= mem_data_out;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] r_ld_count;
    logic [15:0] r_st_count;
    logic [15:0] r_fault_count;
    logic        w_rsp_xfer;

    assign w_rsp_xfer = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_count    <= '0;
            r_st_count    <= '0;
            r_fault_count <= '0;
        end else if (w_rsp_xfer) begin
            if (r_rsp_fault) begin
                if (r_fault_count != 16'hFFFF) r_fault_count <= r_fault_count + 16'd1;
            end else if (r_op == OP_LD) begin
                if (r_ld_count != 16'hFFFF) r_ld_count <= r_ld_count + 16'd1;
            end else if (r_op == OP_ST) begin
                if (r_st_count != 16'hFFFF) r_st_count <= r_st_count + 16'd1;
            end
        end
    end

    assign ld_count    = r_ld_count;
    assign st_count    = r_st_count;
    assign fault_count = r_fault_count;
`endif

endmodule
`default_nettype wire
